// File: rtl/ddr2_bank_timer.sv
// ---------------------------------------------------------------------------
// ddr2_bank_timer
//
// Purpose:
//   Tracks the open/closed state of every DDR2 bank. Enforces the inter-command
//   timing for the commands the controller actually puts on the DRAM bus.
//   Each bank has its own tRCD/tRAS/tRC/tRP timers. tRRD (ACT to ACT on any
//   bank) and tRFC (REF to anything) are shared. The *_ok outputs tell the
//   scheduler what it may issue this cycle. cmd_err flags any command that
//   was issued without permission. Such a command has no effect on the
//   tracked state.
//
// Timer convention:
//   A command accepted in cycle N loads T-1 on the edge that ends cycle N.
//   The timer then counts down once per cycle and saturates at zero, so the
//   dependent permission becomes true in cycle N+T.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   cmd_valid    in   a command is on the DRAM bus this cycle
//   cmd          in   [3:0] DDR2 command encoding (see ddr2_cmd_t)
//   cmd_bank     in   [2:0] target bank
//   cmd_row      in   [13:0] row address, meaningful for ACT
//   bank_state   out  [NUM_BANKS][2:0] per-bank bank_state_t
//   open_row     out  [NUM_BANKS][13:0] row latched by the last accepted ACT
//   act_ok       out  [NUM_BANKS] ACT permitted to that bank
//   rdwr_ok      out  [NUM_BANKS] RD/WR permitted to that bank
//   pre_ok       out  [NUM_BANKS] PRE permitted to that bank
//   ref_ok       out  REF/MRS permitted
//   cmd_err      out  one-cycle pulse after an illegal command
// ---------------------------------------------------------------------------
module ddr2_bank_timer #(
  parameter int NUM_BANKS = 8,
  parameter int T_RCD     = 15,
  parameter int T_RP      = 15,
  parameter int T_RAS     = 40,
  parameter int T_RC      = 55,
  parameter int T_RRD     = 10,
  parameter int T_RFC     = 55,
  parameter int CNT_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  input  logic [3:0]                  cmd,
  input  logic [2:0]                  cmd_bank,
  input  logic [13:0]                 cmd_row,
  output logic [NUM_BANKS-1:0][2:0]   bank_state,
  output logic [NUM_BANKS-1:0][13:0]  open_row,
  output logic [NUM_BANKS-1:0]        act_ok,
  output logic [NUM_BANKS-1:0]        rdwr_ok,
  output logic [NUM_BANKS-1:0]        pre_ok,
  output logic                        ref_ok,
  output logic                        cmd_err
);

  typedef enum logic [3:0] {
    CMD_MRS = 4'b0000,
    CMD_REF = 4'b0001,
    CMD_PRE = 4'b0010,
    CMD_ACT = 4'b0011,
    CMD_WR  = 4'b0100,
    CMD_RD  = 4'b0101,
    CMD_NOP = 4'b0111,
    CMD_DES = 4'b1000
  } ddr2_cmd_t;

  typedef enum logic [2:0] {
    BANK_IDLE       = 3'd0,
    BANK_ACTIVATING = 3'd1,
    BANK_ACTIVE     = 3'd2,
    BANK_PRECHARGE  = 3'd3
  } bank_state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LOAD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LOAD_RP  = CNT_W'(T_RP  - 1);
  localparam logic [CNT_W-1:0] LOAD_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LOAD_RC  = CNT_W'(T_RC  - 1);
  localparam logic [CNT_W-1:0] LOAD_RRD = CNT_W'(T_RRD - 1);
  localparam logic [CNT_W-1:0] LOAD_RFC = CNT_W'(T_RFC - 1);

  // Registered state and its next-state copies
  bank_state_t      state_q    [NUM_BANKS];
  bank_state_t      state_d    [NUM_BANKS];
  logic [CNT_W-1:0] rcd_cnt_q  [NUM_BANKS];
  logic [CNT_W-1:0] rcd_cnt_d  [NUM_BANKS];
  logic [CNT_W-1:0] ras_cnt_q  [NUM_BANKS];
  logic [CNT_W-1:0] ras_cnt_d  [NUM_BANKS];
  logic [CNT_W-1:0] rc_cnt_q   [NUM_BANKS];
  logic [CNT_W-1:0] rc_cnt_d   [NUM_BANKS];
  logic [CNT_W-1:0] rp_cnt_q   [NUM_BANKS];
  logic [CNT_W-1:0] rp_cnt_d   [NUM_BANKS];
  logic [13:0]      row_q      [NUM_BANKS];
  logic [13:0]      row_d      [NUM_BANKS];
  logic [CNT_W-1:0] rrd_cnt_q, rrd_cnt_d;
  logic [CNT_W-1:0] rfc_cnt_q, rfc_cnt_d;
  logic             cmd_err_q, cmd_err_d;

  // Command decode
  logic [NUM_BANKS-1:0] bank_sel;
  logic is_act, is_pre, is_rdwr, is_ref, is_mrs;
  logic act_accept, pre_accept, rdwr_legal, ref_accept, mrs_legal;
  logic cmd_illegal;
  logic all_idle;

  // Saturating down-count shared by every timer
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_ONE;
  endfunction

  // Permissions depend only on registered state, never on the current command,
  // so the scheduler can use them in the same cycle without a loop.
  always_comb begin
    act_ok   = '0;
    rdwr_ok  = '0;
    pre_ok   = '0;
    all_idle = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_ok[b]  = (state_q[b] == BANK_IDLE) && (rc_cnt_q[b] == '0) &&
                   (rrd_cnt_q == '0) && (rfc_cnt_q == '0);
      rdwr_ok[b] = (state_q[b] == BANK_ACTIVE);
      pre_ok[b]  = (state_q[b] == BANK_ACTIVE) && (ras_cnt_q[b] == '0);
      if (state_q[b] != BANK_IDLE) begin
        all_idle = 1'b0;
      end
    end
    ref_ok = all_idle && (rfc_cnt_q == '0);
  end

  // One-hot bank select. A bank number beyond NUM_BANKS selects nothing,
  // so any bank-directed command to it is rejected as illegal.
  always_comb begin
    bank_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_sel[b] = (cmd_bank == 3'(b));
    end
  end

  // Classify the command on the bus. NOP, DES and undefined encodings fall
  // through every case and are ignored.
  always_comb begin
    is_act  = cmd_valid && (cmd == CMD_ACT);
    is_pre  = cmd_valid && (cmd == CMD_PRE);
    is_rdwr = cmd_valid && ((cmd == CMD_RD) || (cmd == CMD_WR));
    is_ref  = cmd_valid && (cmd == CMD_REF);
    is_mrs  = cmd_valid && (cmd == CMD_MRS);

    act_accept = is_act  && |(bank_sel & act_ok);
    pre_accept = is_pre  && |(bank_sel & pre_ok);
    rdwr_legal = is_rdwr && |(bank_sel & rdwr_ok);
    ref_accept = is_ref  && ref_ok;
    mrs_legal  = is_mrs  && ref_ok;

    cmd_illegal = (is_act  && !act_accept) ||
                  (is_pre  && !pre_accept) ||
                  (is_rdwr && !rdwr_legal) ||
                  (is_ref  && !ref_accept) ||
                  (is_mrs  && !mrs_legal);
  end

  // Per-bank next state and timers. Every timer first free-runs down. An
  // accepted command then overrides the timers it restarts. A rejected
  // command matches neither accept term, so it leaves everything alone.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      state_d[b]   = state_q[b];
      rcd_cnt_d[b] = dec_sat(rcd_cnt_q[b]);
      ras_cnt_d[b] = dec_sat(ras_cnt_q[b]);
      rc_cnt_d[b]  = dec_sat(rc_cnt_q[b]);
      rp_cnt_d[b]  = dec_sat(rp_cnt_q[b]);
      row_d[b]     = row_q[b];

      // Time-driven transitions fire on the edge where the governing timer
      // reaches zero.
      case (state_q[b])
        BANK_ACTIVATING: begin
          if (rcd_cnt_q[b] == CNT_ONE) begin
            state_d[b] = BANK_ACTIVE;
          end
        end
        BANK_PRECHARGE: begin
          if (rp_cnt_q[b] == CNT_ONE) begin
            state_d[b] = BANK_IDLE;
          end
        end
        default: begin
        end
      endcase

      if (act_accept && bank_sel[b]) begin
        state_d[b]   = BANK_ACTIVATING;
        rcd_cnt_d[b] = LOAD_RCD;
        ras_cnt_d[b] = LOAD_RAS;
        rc_cnt_d[b]  = LOAD_RC;
        row_d[b]     = cmd_row;
      end

      // rc_cnt is deliberately left running here. It keeps gating act_ok
      // after the bank has returned to IDLE.
      if (pre_accept && bank_sel[b]) begin
        state_d[b]  = BANK_PRECHARGE;
        rp_cnt_d[b] = LOAD_RP;
      end
    end
  end

  // Shared timers and the error pulse
  always_comb begin
    rrd_cnt_d = dec_sat(rrd_cnt_q);
    rfc_cnt_d = dec_sat(rfc_cnt_q);
    if (act_accept) begin
      rrd_cnt_d = LOAD_RRD;
    end
    if (ref_accept) begin
      rfc_cnt_d = LOAD_RFC;
    end
    cmd_err_d = cmd_illegal;
  end

  // State register. Reset abandons any timing in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]   <= BANK_IDLE;
        rcd_cnt_q[b] <= '0;
        ras_cnt_q[b] <= '0;
        rc_cnt_q[b]  <= '0;
        rp_cnt_q[b]  <= '0;
        row_q[b]     <= '0;
      end
      rrd_cnt_q <= '0;
      rfc_cnt_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state_q[b]   <= state_d[b];
        rcd_cnt_q[b] <= rcd_cnt_d[b];
        ras_cnt_q[b] <= ras_cnt_d[b];
        rc_cnt_q[b]  <= rc_cnt_d[b];
        rp_cnt_q[b]  <= rp_cnt_d[b];
        row_q[b]     <= row_d[b];
      end
      rrd_cnt_q <= rrd_cnt_d;
      rfc_cnt_q <= rfc_cnt_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Flatten the internal arrays onto the output ports
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_state[b] = state_q[b];
      open_row[b]   = row_q[b];
    end
    cmd_err = cmd_err_q;
  end

endmodule
